// File: rtl/fp_pkg.sv
// Shared types and constants for the sequential FP32 adder.
package fp_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_WRITE = 3'd5
  } fp_state_e;

  localparam int SIGN_W   = 1;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int EXT_W    = 27;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  // Significand with hidden bit; subnormals flush to zero.
  function automatic logic [FRAC_W:0] unpack_sig(input logic [EXP_W+FRAC_W-1:0] x);
    return (x[EXP_W+FRAC_W-1:FRAC_W] == '0) ? '0 : {1'b1, x[FRAC_W-1:0]};
  endfunction

endpackage

// File: rtl/fp_add_core_if.sv
// Operand/result handshake bundle between the producer, the adder and the output register.
interface fp_add_core_if;
  import fp_pkg::*;

  // Operands transfer on a clock edge where start_in & in_rdy_out; the result
  // transfers on a clock edge where wr_out (which already implies out_rdy_in).
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        start_in;
  logic        in_rdy_out;
  logic        out_rdy_in;
  logic        wr_out;
  logic [31:0] result_out;
  fp_state_e   state_dbg;

  modport master (
    output a_in, b_in, start_in, out_rdy_in,
    input  in_rdy_out, wr_out, result_out, state_dbg
  );

  modport slave (
    input  a_in, b_in, start_in, out_rdy_in,
    output in_rdy_out, wr_out, result_out, state_dbg
  );

endinterface

// File: rtl/fp_lzc.sv
// 28-bit leading-zero counter; an all-zero input reports 28.
module fp_lzc
  import fp_pkg::*;
(
  input  logic [EXT_W:0] i_data,
  output logic [4:0]     o_count
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    o_count = 5'd28;
    for (int i = 0; i <= EXT_W; i++) begin
      if (i_data[i]) o_count = 5'(EXT_W - i);
    end
  end

endmodule

// File: rtl/fp_add_core.sv
// Sequential FP32 adder (RNE, subnormals flushed), one operation per six cycles,
// feeding the serial output register through a write/ready handshake.
module fp_add_core
  import fp_pkg::*;
(
  input logic          clk_in,
  input logic          rst_in,
  fp_add_core_if.slave bus
);

  fp_state_e         r_state, w_next;
  logic [31:0]       r_a, r_b, r_spec_res, r_result;
  logic              r_sign, r_sub, r_special;
  logic signed [9:0] r_exp;
  logic [EXT_W-1:0]  r_sig_l, r_sig_s, r_norm;
  logic [EXT_W:0]    r_sum;

  always_ff @(posedge clk_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_in) w_next = S_ALIGN;
      S_ALIGN: w_next = S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM:  w_next = S_ROUND;
      S_ROUND: w_next = S_WRITE;
      S_WRITE: if (bus.out_rdy_in) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.in_rdy_out = (r_state == S_IDLE);
  assign bus.wr_out     = (r_state == S_WRITE) && bus.out_rdy_in;
  assign bus.result_out = r_result;
  assign bus.state_dbg  = r_state;

  // ALIGN: unpack, order by magnitude, shift the smaller operand with sticky.
  logic              w_sa, w_sb, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap, w_l_sign;
  logic [EXP_W-1:0]  w_ea, w_eb, w_l_exp, w_s_exp, w_diff;
  logic [FRAC_W-1:0] w_fa, w_fb;
  logic [FRAC_W:0]   w_l_sig, w_s_sig;
  logic [30:0]       w_mag_a, w_mag_b;
  logic [EXT_W-1:0]  w_ext, w_aligned;
  logic              w_special;
  logic [31:0]       w_spec_res;

  assign {w_sa, w_ea, w_fa} = r_a;
  assign {w_sb, w_eb, w_fb} = r_b;
  assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != '0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != '0);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == '0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == '0);
  assign w_mag_a  = (w_ea == '0) ? '0 : r_a[30:0];
  assign w_mag_b  = (w_eb == '0) ? '0 : r_b[30:0];
  assign w_swap   = (w_mag_b > w_mag_a);
  assign w_l_sign = w_swap ? w_sb : w_sa;
  assign w_l_exp  = w_swap ? w_eb : w_ea;
  assign w_s_exp  = w_swap ? w_ea : w_eb;
  assign w_l_sig  = unpack_sig(w_swap ? r_b[30:0] : r_a[30:0]);
  assign w_s_sig  = unpack_sig(w_swap ? r_a[30:0] : r_b[30:0]);
  assign w_diff   = w_l_exp - w_s_exp;
  assign w_ext    = {w_s_sig, 3'b000};

  always_comb begin
    w_aligned = '0;
    if (w_diff >= 8'(EXT_W)) w_aligned = {{(EXT_W-1){1'b0}}, |w_s_sig};
    else w_aligned = (w_ext >> w_diff) |
                     {{(EXT_W-1){1'b0}}, |(w_ext & ~({EXT_W{1'b1}} << w_diff))};
  end

  always_comb begin
    w_special  = w_a_nan | w_b_nan | w_a_inf | w_b_inf;
    w_spec_res = QNAN;
    if (!(w_a_nan || w_b_nan)) begin
      if (w_a_inf && w_b_inf && (w_sa != w_sb)) w_spec_res = QNAN;
      else if (w_a_inf)                         w_spec_res = r_a;
      else if (w_b_inf)                         w_spec_res = r_b;
    end
  end

  // NORM: put the leading one at bit 26 of the extended field.
  logic [4:0]        w_lz, w_shamt;
  logic [EXT_W:0]    w_shl;
  logic [EXT_W-1:0]  w_norm;
  logic signed [9:0] w_norm_exp;
  logic              w_norm_sign;

  fp_lzc u_lzc (.i_data(r_sum), .o_count(w_lz));

  assign w_shamt = w_lz - 5'd1;
  assign w_shl   = r_sum << w_shamt;

  always_comb begin
    w_norm      = '0;
    w_norm_exp  = '0;
    w_norm_sign = r_sign;
    if (r_sum == '0) begin
      w_norm_sign = r_sub ? 1'b0 : r_sign;
    end else if (r_sum[EXT_W]) begin
      w_norm     = {r_sum[EXT_W:2], r_sum[1] | r_sum[0]};
      w_norm_exp = r_exp + 10'sd1;
    end else begin
      w_norm     = w_shl[EXT_W-1:0];
      w_norm_exp = r_exp - $signed({5'b00000, w_shamt});
    end
    if (w_norm_exp <= 10'sd0) begin
      w_norm     = '0;
      w_norm_exp = '0;
    end
  end

  // ROUND: nearest-even on the guard/round/sticky bits, then pack.
  logic              w_inc;
  logic [FRAC_W+1:0] w_rnd;
  logic signed [9:0] w_rnd_exp;
  logic [31:0]       w_packed;

  assign w_inc     = r_norm[2] & (r_norm[1] | r_norm[0] | r_norm[3]);
  assign w_rnd     = {1'b0, r_norm[EXT_W-1:3]} + {{(FRAC_W+1){1'b0}}, w_inc};
  assign w_rnd_exp = r_exp + (w_rnd[FRAC_W+1] ? 10'sd1 : 10'sd0);

  always_comb begin
    if (w_rnd_exp >= 10'(EXP_MAX))
      w_packed = {r_sign, POS_INF[30:0]};
    else
      w_packed = {r_sign, w_rnd_exp[EXP_W-1:0],
                  w_rnd[FRAC_W+1] ? w_rnd[FRAC_W:1] : w_rnd[FRAC_W-1:0]};
    if (r_special) w_packed = r_spec_res;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_a <= '0;  r_b <= '0;  r_spec_res <= '0;  r_result <= '0;
      r_sign <= 1'b0;  r_sub <= 1'b0;  r_special <= 1'b0;  r_exp <= '0;
      r_sig_l <= '0;  r_sig_s <= '0;  r_norm <= '0;  r_sum <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start_in) begin
          r_a <= bus.a_in;
          r_b <= bus.b_in;
        end
        S_ALIGN: begin
          r_sign     <= w_l_sign;
          r_sub      <= w_sa ^ w_sb;
          r_exp      <= {2'b00, w_l_exp};
          r_sig_l    <= {w_l_sig, 3'b000};
          r_sig_s    <= w_aligned;
          r_special  <= w_special;
          r_spec_res <= w_spec_res;
        end
        S_ADD: r_sum <= r_sub ? ({1'b0, r_sig_l} - {1'b0, r_sig_s})
                              : ({1'b0, r_sig_l} + {1'b0, r_sig_s});
        S_NORM: begin
          r_norm <= w_norm;
          r_exp  <= w_norm_exp;
          r_sign <= w_norm_sign;
        end
        S_ROUND: r_result <= w_packed;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_core.sv
// Randomized bench for fp_add_core against an exact-arithmetic FP32 reference.
module tb_fp_add_core;
  import fp_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fp_add_core_if bus();

  fp_add_core dut (.clk_in(clk), .rst_in(rst_n), .bus(bus.slave));

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_errs);
    $fatal(1, "watchdog");
  end

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: sum the operands exactly as scaled integers, then round once.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic sa, sb, sr;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    logic [299:0] ma, mb, s, rem, half;
    logic [24:0] m;
    logic inc;
    int p, e;
    {sa, ea, fa} = a;
    {sb, eb, fb} = b;
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0)) return QNAN;
    if (ea == 8'hFF && eb == 8'hFF) return (sa == sb) ? a : QNAN;
    if (ea == 8'hFF) return a;
    if (eb == 8'hFF) return b;
    ma = (ea == 0) ? 300'd0 : (300'({1'b1, fa}) << (ea - 8'd1));
    mb = (eb == 0) ? 300'd0 : (300'({1'b1, fb}) << (eb - 8'd1));
    if (sa == sb)      begin s = ma + mb; sr = sa; end
    else if (ma >= mb) begin s = ma - mb; sr = sa; end
    else               begin s = mb - ma; sr = sb; end
    if (s == 0) return {(sa == sb) ? sa : 1'b0, 31'd0};
    p = 0;
    for (int i = 0; i < 300; i++) if (s[i]) p = i;
    e = p - 149 + EXP_BIAS;
    if (e <= 0) return {sr, 31'd0};
    m = 25'(s >> (p - 23));
    inc = 1'b0;
    if (p > 23) begin
      rem  = s & ((300'd1 << (p - 23)) - 300'd1);
      half = 300'd1 << (p - 24);
      inc  = (rem > half) || ((rem == half) && m[0]);
    end
    if (inc) m = m + 25'd1;
    if (m[24]) begin m = m >> 1; e++; end
    if (e >= EXP_MAX) return {sr, 8'hFF, 23'd0};
    return {sr, 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] rand_op(input int base_e);
    logic s;
    int e;
    logic [22:0] f;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    case ($urandom_range(0, 11))
      0: return $urandom;
      1: return {s, 31'd0};
      2: return {s, 8'h00, f};
      3: return {s, 8'hFF, 23'd0};
      4: return {s, 8'hFF, f | 23'd1};
      5: e = int'($urandom_range(250, 254));
      6: e = int'($urandom_range(1, 4));
      default: begin
        e = base_e + int'($urandom_range(0, 60)) - 30;
        if (e < 1)   e = 1;
        if (e > 254) e = 254;
      end
    endcase
    return {s, 8'(e), f};
  endfunction

  // scoreboard: every write strobe consumes one expected result
  always @(negedge clk) begin
    if (rst_n && bus.wr_out) begin
      check("wr_needs_rdy", 32'(bus.out_rdy_in), 32'd1);
      if (exp_q.size() == 0) check("spurious_wr", 32'(bus.wr_out), 32'd0);
      else                   check("result", bus.result_out, exp_q.pop_front());
    end
  end

  // driver tasks (inputs change 1 time unit after the rising edge)
  task automatic wait_idle();
    int n = 0;
    while (!bus.in_rdy_out && n < 20) begin @(posedge clk); #1; n++; end
    check("idle_rdy", 32'(bus.in_rdy_out), 32'd1);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int stall, input bit poke);
    logic [31:0] exp_v;
    wait_idle();
    exp_v = ref_add(a, b);
    exp_q.push_back(exp_v);
    bus.a_in = a;  bus.b_in = b;  bus.start_in = 1'b1;
    bus.out_rdy_in = (stall == 0);
    @(posedge clk); #1;
    if (poke) begin bus.a_in = $urandom; bus.b_in = $urandom; end
    else bus.start_in = 1'b0;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      check("early_wr", 32'(bus.wr_out), 32'd0);
      check("busy_rdy", 32'(bus.in_rdy_out), 32'd0);
      @(posedge clk); #1;
    end
    bus.start_in = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_wr", 32'(bus.wr_out), 32'd0);
      check("stall_res", bus.result_out, exp_v);
      @(posedge clk); #1;
    end
    bus.out_rdy_in = 1'b1;
    @(negedge clk);
    check("wr_pulse", 32'(bus.wr_out), 32'd1);
    @(posedge clk); #1;
    check("rdy_back", 32'(bus.in_rdy_out), 32'd1);
    @(negedge clk);
    check("single_wr", 32'(bus.wr_out), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_op(input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    bus.a_in = a;  bus.b_in = b;  bus.start_in = 1'b1;  bus.out_rdy_in = 1'b1;
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("in_norm", 32'(bus.state_dbg), 32'(S_NORM));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_state", 32'(bus.state_dbg), 32'(S_IDLE));
    check("rst_rdy", 32'(bus.in_rdy_out), 32'd1);
    check("rst_result", bus.result_out, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no_wr_after_rst", 32'(bus.wr_out), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] dir_a [11] = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h3F800000,
                              32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800000,
                              32'h7FC00001, 32'h00000001, 32'h3F800000};
  logic [31:0] dir_b [11] = '{32'h40000000, 32'hBF800000, 32'h80000000, 32'h33800000,
                              32'h33800001, 32'h7F800000, 32'h7F7FFFFF, 32'hFF800000,
                              32'h3F800000, 32'h00000000, 32'h40000000};
  logic [31:0] dir_e [11] = '{32'h40400000, 32'h00000000, 32'h80000000, 32'h3F800000,
                              32'h3F800001, 32'h7F800000, 32'h7F800000, 32'h7FC00000,
                              32'h7FC00000, 32'h00000000, 32'h40400000};

  initial begin
    logic [31:0] ra, rb;
    int be;
    bus.a_in = '0;  bus.b_in = '0;  bus.start_in = 1'b0;  bus.out_rdy_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(bus.state_dbg), 32'(S_IDLE));
    check("reset_rdy", 32'(bus.in_rdy_out), 32'd1);
    check("reset_wr", 32'(bus.wr_out), 32'd0);
    check("reset_result", bus.result_out, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      check("model_vs_table", ref_add(dir_a[i], dir_b[i]), dir_e[i]);
      do_op(dir_a[i], dir_b[i], 0, 1'b0);
    end
    do_op(32'h3F800000, 32'h40000000, 3, 1'b1);
    reset_mid_op(32'h40A00000, 32'h3F800000);

    for (int i = 0; i < 300; i++) begin
      be = int'($urandom_range(20, 230));
      ra = rand_op(be);
      if ($urandom_range(0, 7) == 0) rb = ra ^ 32'h80000000 ^ 32'($urandom_range(0, 3));
      else                           rb = rand_op(be);
      do_op(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
            1'($urandom_range(0, 1)));
    end

    repeat (10) @(posedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
